// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bundle for the shared data-memory port arbiter.
// A transfer happens in a cycle where valid and ready are both high; valid may drop while not granted.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      mem_valid;
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_REQ requesters,
// one transaction in flight, misaligned word accesses answered with an error.
module mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  mem_port_arbiter_if.slave          bus,
  output logic                       busy,
  output logic [1:0]                 dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W:0]   cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && bus.req_valid[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  logic [PTR_W:0]   winner_inc;
  logic [PTR_W-1:0] next_ptr;

  assign winner_inc = {1'b0, winner} + (PTR_W+1)'(1);
  assign next_ptr   = (winner_inc == (PTR_W+1)'(NUM_REQ)) ? '0 : winner_inc[PTR_W-1:0];

  logic aligned;
  assign aligned = (addr_q[1:0] == 2'b00);

  logic [NUM_REQ-1:0] req_ready_c;
  logic [NUM_REQ-1:0] resp_valid_c;
  logic               mem_valid_c;
  logic               mem_read_c;
  logic               mem_write_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [DATA_W-1:0]  mem_wdata_c;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_c  = '0;
    resp_valid_c = '0;
    mem_valid_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        // reset gating keeps req_ready low while reset is held
        if (found && reset) begin
          req_ready_c[winner] = 1'b1;
          addr_d   = addr_arr[winner];
          wdata_d  = wdata_arr[winner];
          write_d  = bus.req_write[winner];
          owner_d  = winner;
          rr_ptr_d = next_ptr;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (aligned) begin
          mem_valid_c = 1'b1;
          mem_read_c  = !write_q;
          mem_write_c = write_q;
          mem_addr_c  = addr_q;
          mem_wdata_c = wdata_q;
          rdata_d     = write_q ? '0 : bus.mem_rdata;
          err_d       = 1'b0;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_c[owner_q] = 1'b1;
        if (bus.resp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_valid  = mem_valid_c;
  assign bus.mem_read   = mem_read_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;

  assign busy         = (state_q != ST_IDLE);
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory access port between NUM_REQ requesters: load unit, store-commit path and debug/init loader.
- Sits between the execution back end and main memory, and converts each requester's valid/ready request into exactly one memory access.
- Returns a registered response to the owning requester.
- Round-robin grant; one transaction in flight; misaligned word accesses are rejected without touching memory.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (word = 4 bytes)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_write  in  NUM_REQ  1=store, 0=load
- req_addr  in  NUM_REQ*ADDR_W  request byte addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  store data, packed as req_addr
- resp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_rdata  out  DATA_W  load data (0 for stores and errors)
- resp_err  out  1  misaligned access flag, qualified by resp_valid
- mem_valid  out  1  memory access strobe
- mem_read  out  1  load strobe
- mem_write  out  1  store strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory store data
- mem_rdata  in  DATA_W  combinational read data from memory, same cycle as mem_valid
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (reset low, asynchronous) clears everything immediately:
  - state=IDLE, rr_ptr=0, owner=0
  - holding registers = 0
  - all outputs 0 (req_ready, resp_valid, mem_* , resp_rdata, resp_err, busy)
  - an in-flight transaction is dropped with no response; a store not yet in ACCESS is not written.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in IDLE only; all other req_ready bits are 0.
  - On accept: latch addr, wdata, write and owner=winner; rr_ptr <= (winner+1) mod NUM_REQ; go to ACCESS.
  - No valid request: stay in IDLE; rr_ptr is unchanged.
- ACCESS (exactly one cycle):
  - If latched addr[1:0]==0: mem_valid=1, mem_read=!write, mem_write=write, mem_addr/mem_wdata from the holding registers. Capture resp_rdata <= write ? 0 : mem_rdata; resp_err <= 0.
  - If addr[1:0]!=0: mem_valid, mem_read and mem_write stay 0; resp_rdata <= 0; resp_err <= 1.
  - Then go to RESP.
- RESP:
  - resp_valid[owner]=1; resp_rdata and resp_err are held stable.
  - On resp_ready[owner]: go to IDLE the next cycle.
  - Otherwise hold indefinitely; no new request is accepted while in RESP.
- mem_* outputs are 0 in every state except ACCESS; mem_read and mem_write are never both 1.
- Latency: accept in cycle T, memory access in T+1, resp_valid in T+2. Minimum issue interval is 3 cycles.
- Requests are serviced strictly in accept order, so store-then-load to the same address returns the new data.
- A requester dropping req_valid while not granted is legal; the arbiter does not require stable valid.
- rr_ptr arithmetic is modulo NUM_REQ; it wraps from NUM_REQ-1 to 0.

Test Plan:
- Single store then load: requester 1 stores 0xDEADBEEF to addr 0x08, then loads addr 0x08. Required:
  - mem_write pulses one cycle with addr 0x08.
  - Load resp_valid[1] arrives 2 cycles after accept with rdata 0xDEADBEEF, resp_err=0.
- Fairness: all three req_valid held high for 9 requests. Required:
  - Grant order 0,1,2,0,1,2,0,1,2.
  - req_ready is never multi-hot.
- Backpressure: hold resp_ready[2]=0 for 5 cycles during a load by requester 2. Required:
  - resp_valid[2] and rdata stay stable for all 5 cycles.
  - No req_ready is asserted until one cycle after resp_ready[2] rises.
- Misaligned access: store to addr 0x06. Required:
  - mem_valid stays 0.
  - resp_err=1, resp_rdata=0.
  - A following load of 0x04 returns the previous contents unchanged.
- Pointer wrap: rr_ptr=2 with only requester 0 valid. Required:
  - Requester 0 is granted.
  - rr_ptr becomes 1.
  - Next simultaneous requests from 0 and 1 grant 1 first.
- Reset mid-operation: assert reset low during ACCESS of a store to 0x10. Required:
  - All outputs go to 0 asynchronously; no resp_valid follows.
  - After release, the first grant goes to requester 0.
